// File: rtl/alu_result_buffer_if.sv
// Valid/ready channels between the ALU, the result buffer and the writeback stage.
// The slave view belongs to the buffer; the master view belongs to its surroundings.
interface alu_result_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_cout;
  logic [3:0]       in_fun;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_cout;
  logic             out_zero;
  logic             out_err;
  logic [3:0]       out_fun;

  modport master (
    output in_valid, in_y, in_cout, in_fun, out_ready,
    input  in_ready, out_valid, out_y, out_cout, out_zero, out_err, out_fun
  );

  modport slave (
    input  in_valid, in_y, in_cout, in_fun, out_ready,
    output in_ready, out_valid, out_y, out_cout, out_zero, out_err, out_fun
  );
endinterface

// File: rtl/alu_result_buffer.sv
// DEPTH-entry FIFO of ALU results with derived zero/illegal flags, a sticky carry
// and an occupancy count. The head entry is held in a register so out_* are glitch-free.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_buffer_if.slave     bus,
  input  logic                   flag_clr,
  output logic [AW:0]            count,
  output logic                   carry_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic [3:0]       fun;
    logic             zero;
    logic             err;
  } entry_t;

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          in_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic            push;
  logic            pop;
  logic [AW:0]     level_after_pop;
  logic [AW:0]     count_next;

  assign in_entry = '{
    y:    bus.in_y,
    cout: bus.in_cout,
    fun:  bus.in_fun,
    zero: (bus.in_y == '0),
    err:  (bus.in_fun > 4'b0110)
  };

  // Handshakes depend on the count register only, never on the other side's strobe.
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    rd_next         = rd_ptr + AW'(pop);
    level_after_pop = count - (AW + 1)'(pop);
    count_next      = level_after_pop + (AW + 1)'(push);
  end

  // NOTE: the storage array has no reset; the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      carry_sticky <= 1'b0;
      head         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count_next;

      // A carry arriving in the same cycle as a clear must not be lost.
      if (push && bus.in_cout) carry_sticky <= 1'b1;
      else if (flag_clr)       carry_sticky <= 1'b0;

      // Preload the next head; an entry pushed into an emptied FIFO becomes the head directly.
      if (count_next != '0) begin
        if (push && (level_after_pop == '0)) head <= in_entry;
        else                                 head <= mem[rd_next];
      end
    end
  end

  assign bus.out_y    = head.y;
  assign bus.out_cout = head.cout;
  assign bus.out_zero = head.zero;
  assign bus.out_err  = head.err;
  assign bus.out_fun  = head.fun;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: a queue scoreboard tracks expected FIFO contents,
// occupancy and sticky carry, and every cycle the DUT state is compared against it.
module tb_alu_result_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic [3:0]       fun;
    logic             zero;
    logic             err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_clr;
  logic [AW:0] count;
  logic        carry_sticky;

  alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flag_clr     (flag_clr),
    .count        (count),
    .carry_sticky (carry_sticky)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t last_head;
  int   m_count;
  logic m_sticky;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make(input logic [WIDTH-1:0] y, input logic c, input logic [3:0] f);
    exp_t e;
    e.y    = y;
    e.cout = c;
    e.fun  = f;
    e.zero = (y == 32'd0);
    e.err  = (f > 4'd6);
    return e;
  endfunction

  task automatic check_state(input string tag);
    exp_t h;
    h = (sb.size() != 0) ? sb[0] : last_head;
    check({tag, ".count"},     64'(count), 64'(m_count));
    check({tag, ".in_ready"},  64'(bus.in_ready), 64'(m_count != DEPTH));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_count != 0));
    check({tag, ".sticky"},    64'(carry_sticky), 64'(m_sticky));
    check({tag, ".out_y"},     64'(bus.out_y), 64'(h.y));
    check({tag, ".out_cout"},  64'(bus.out_cout), 64'(h.cout));
    check({tag, ".out_zero"},  64'(bus.out_zero), 64'(h.zero));
    check({tag, ".out_err"},   64'(bus.out_err), 64'(h.err));
    check({tag, ".out_fun"},   64'(bus.out_fun), 64'(h.fun));
  endtask

  // Drive one cycle of stimulus, check the pre-edge state, then advance the model.
  task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] y,
                       input logic c, input logic [3:0] f, input logic ordy, input logic clr);
    bit do_push, do_pop;
    bus.in_valid  = v;
    bus.in_y      = y;
    bus.in_cout   = c;
    bus.in_fun    = f;
    bus.out_ready = ordy;
    flag_clr      = clr;
    check_state(tag);
    do_push = v && (m_count != DEPTH);
    do_pop  = ordy && (m_count != 0);
    if (do_pop)  void'(sb.pop_front());
    if (do_push) sb.push_back(make(y, c, f));
    m_count = sb.size();
    if (do_push && c) m_sticky = 1'b1;
    else if (clr)     m_sticky = 1'b0;
    @(posedge clk);
    #1;
    if (sb.size() != 0) last_head = sb[0];
  endtask

  task automatic apply_reset(input logic v);
    rst           = 1'b1;
    bus.in_valid  = v;
    bus.in_y      = 32'h1234_5678;
    bus.in_cout   = 1'b1;
    bus.in_fun    = 4'b0011;
    bus.out_ready = 1'b0;
    flag_clr      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_count   = 0;
    m_sticky  = 1'b0;
    last_head = '0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.in_cout   = 1'b0;
    bus.in_fun    = '0;
    bus.out_ready = 1'b0;
    flag_clr      = 1'b0;
    @(posedge clk);
    apply_reset(1'b0);
    check_state("reset");

    // Three pushes held, then drained in order.
    cycle("t1_push0", 1, 32'd5,          0, 4'b0000, 0, 0);
    cycle("t1_push1", 1, 32'd0,          0, 4'b0010, 0, 0);
    cycle("t1_push2", 1, 32'hFFFF_FFFF,  1, 4'b0001, 0, 0);
    cycle("t1_hold",  0, 32'd0,          0, 4'b0000, 0, 0);
    check("t1_count3", 64'(count), 64'd3);
    check("t1_sticky", 64'(carry_sticky), 64'd1);
    cycle("t1_pop0",  0, 32'd0, 0, 4'b0000, 1, 0);
    check("t1_second_zero", 64'(bus.out_zero), 64'd1);
    cycle("t1_pop1",  0, 32'd0, 0, 4'b0000, 1, 0);
    cycle("t1_pop2",  0, 32'd0, 0, 4'b0000, 1, 0);
    cycle("t1_empty", 0, 32'd0, 0, 4'b0000, 0, 0);

    // Fill to DEPTH, try a fifth push, then push+pop while full.
    for (int i = 0; i < DEPTH; i++)
      cycle("t2_fill", 1, 32'hA0 + 32'(i), 0, 4'(i), 0, 0);
    check("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
    cycle("t2_fifth", 1, 32'hBAD0, 0, 4'b0100, 0, 0);
    cycle("t2_full_pushpop", 1, 32'hBAD1, 0, 4'b0100, 1, 0);
    check("t2_in_ready_after", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < DEPTH; i++)
      cycle("t2_drain", 0, 32'd0, 0, 4'b0000, 1, 0);

    // Streaming push and pop: pointers wrap, occupancy stays at one.
    for (int i = 1; i <= 10; i++) begin
      cycle("t3_stream", 1, 32'(i), 0, 4'b0011, 1, 0);
      check("t3_count_le1", 64'(count <= 1), 64'd1);
    end
    cycle("t3_drain", 0, 32'd0, 0, 4'b0000, 1, 0);
    cycle("t3_idle",  0, 32'd0, 0, 4'b0000, 0, 0);

    // Illegal function code.
    cycle("t4_push", 1, 32'd0, 0, 4'b1001, 0, 0);
    check("t4_err",  64'(bus.out_err),  64'd1);
    check("t4_zero", 64'(bus.out_zero), 64'd1);
    check("t4_fun",  64'(bus.out_fun),  64'h9);
    cycle("t4_pop",  0, 32'd0, 0, 4'b0000, 1, 0);

    // Sticky carry: set beats clear, then a lone clear.
    cycle("t5_clr0",     0, 32'd0, 0, 4'b0000, 0, 1);
    check("t5_cleared",  64'(carry_sticky), 64'd0);
    cycle("t5_set_clr",  1, 32'd7, 1, 4'b0001, 0, 1);
    check("t5_set_wins", 64'(carry_sticky), 64'd1);
    cycle("t5_clr",      0, 32'd0, 0, 4'b0000, 0, 1);
    check("t5_clr_done", 64'(carry_sticky), 64'd0);

    // Reset mid-operation with data queued and a push offered.
    cycle("t6_push_a", 1, 32'd11, 1, 4'b0000, 0, 0);
    cycle("t6_push_b", 1, 32'd12, 0, 4'b0101, 0, 0);
    check("t6_count3", 64'(count), 64'd3);
    apply_reset(1'b1);
    check_state("t6_after_reset");
    check("t6_out_y_zero", 64'(bus.out_y), 64'd0);
    cycle("t6_idle", 0, 32'd0, 0, 4'b0000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
